// File: rtl/spi_slave_if.sv
// SPI slave front end for a small RAM: deserialises {cmd, byte} frames from MOSI
// and serialises one RAM read byte back out on MISO after a read-data frame.
module spi_slave_if #(
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] shift_in_q, shift_in_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       frame_done_q, frame_done_d;
    logic [9:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_flag_q, rd_flag_d;
    logic       armed_q, armed_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       tx_busy_q, tx_busy_d;

    logic in_frame;
    logic last_bit;

    assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    assign last_bit = in_frame && !frame_done_q && (bit_cnt_q == 4'd9);

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)           state_d = IDLE;
                else if (!MOSI)     state_d = WRITE;
                else if (rd_flag_q) state_d = READ_DATA;
                else                state_d = READ_ADD;
            end
            default: begin
                if (SS_n) state_d = IDLE;
            end
        endcase
    end

    // Frame assembly, read-flag tracking and MISO shifter.
    always_comb begin
        shift_in_d   = shift_in_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = frame_done_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rd_flag_d    = rd_flag_q;
        armed_d      = armed_q;
        tx_shift_d   = tx_shift_q;
        tx_cnt_d     = tx_cnt_q;
        tx_busy_d    = tx_busy_q;

        if (in_frame && !frame_done_q) begin
            shift_in_d = {shift_in_q[8:0], MOSI};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (last_bit) begin
                rx_data_d    = {shift_in_q[8:0], MOSI};
                rx_valid_d   = 1'b1;
                frame_done_d = 1'b1;
                bit_cnt_d    = 4'd0;
                if (state_q == READ_ADD) rd_flag_d = 1'b1;
                if (state_q == READ_DATA) begin
                    rd_flag_d = 1'b0;
                    armed_d   = 1'b1;
                end
            end
        end

        // One-shot capture: once loaded, tx_valid is ignored until the next read-data frame.
        if (tx_busy_q) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd7) tx_busy_d = 1'b0;
        end else if (armed_q && (state_q == READ_DATA) && tx_valid) begin
            tx_shift_d = tx_data;
            tx_cnt_d   = 3'd0;
            tx_busy_d  = 1'b1;
            armed_d    = 1'b0;
        end

        // Deselect aborts everything in flight but keeps a frame completing on this edge.
        if (SS_n && (state_q != IDLE)) begin
            shift_in_d   = 10'h000;
            bit_cnt_d    = 4'd0;
            frame_done_d = 1'b0;
            armed_d      = 1'b0;
            tx_busy_d    = 1'b0;
            tx_cnt_d     = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_in_q   <= 10'h000;
            bit_cnt_q    <= 4'd0;
            frame_done_q <= 1'b0;
            rx_data_q    <= 10'h000;
            rx_valid_q   <= 1'b0;
            rd_flag_q    <= 1'b0;
            armed_q      <= 1'b0;
            tx_shift_q   <= 8'h00;
            tx_cnt_q     <= 3'd0;
            tx_busy_q    <= 1'b0;
        end else begin
            shift_in_q   <= shift_in_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rd_flag_q    <= rd_flag_d;
            armed_q      <= armed_d;
            tx_shift_q   <= tx_shift_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    // Output logic.
    always_comb begin
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        MISO     = tx_busy_q ? tx_shift_q[7] : MISO_IDLE;
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: received frames go through a scoreboard queue,
// MISO bits and frame timing are checked inline at each step.
module tb_spi_slave_if;

    localparam logic MI = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [9:0] exp_q[$];
    logic [9:0] last_rx = 10'h000;

    spi_slave_if #(.MISO_IDLE(MI)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every rx_valid pulse must match the oldest frame still expected.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", 32'(rx_valid), 32'(1'b0));
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Drives SS_n low, the R/W bit and 10 bits; returns in the cycle after the 10th-bit edge.
    task automatic send_frame(input logic rw, input logic [9:0] bits, input logic ss_on_last);
        exp_q.push_back(bits);
        last_rx = bits;
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        check("rxv_after_ss", 32'(rx_valid), 32'(1'b0));
        MOSI = rw;
        tick();
        check("rxv_after_rw", 32'(rx_valid), 32'(1'b0));
        for (int i = 9; i >= 0; i--) begin
            MOSI = bits[i];
            if (i == 0 && ss_on_last) SS_n = 1'b1;
            tick();
            check($sformatf("rxv_bit%0d", i), 32'(rx_valid), 32'(i == 0));
            check($sformatf("miso_frame_bit%0d", i), 32'(MISO), 32'(MI));
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        check("rxv_one_cycle", 32'(rx_valid), 32'(1'b0));
        check("rx_data_hold", 32'(rx_data), 32'(last_rx));
    endtask

    task automatic read_back(input logic [7:0] b);
        tx_valid = 1'b0;
        MOSI = 1'b1;
        tick();
        check("miso_wait", 32'(MISO), 32'(MI));
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~b;
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("miso_bit%0d", i), 32'(MISO), 32'(b[i]));
            MOSI = 1'($urandom);
            tick();
        end
        check("miso_after_byte", 32'(MISO), 32'(MI));
    endtask

    // Read-address frames must not arm a capture; a zero byte would show against idle-high.
    task automatic no_capture();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("miso_no_capture", 32'(MISO), 32'(MI));
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] sticky_b;
        logic [7:0] rst_b;
        sticky_b = 8'h96;
        rst_b    = 8'hA5;

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick();
        tick();
        check("rst_rx_data", 32'(rx_data), 32'(10'h000));
        check("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
        check("rst_miso", 32'(MISO), 32'(MI));
        rst_n = 1'b1;
        tick();

        // Write address and write data frames.
        send_frame(1'b0, 10'h00A, 1'b0);
        end_frame();
        send_frame(1'b0, 10'h1A5, 1'b0);
        end_frame();

        // Read address, then read data with a C3 reply; rd_flag must clear afterwards.
        send_frame(1'b1, 10'h20A, 1'b0);
        end_frame();
        send_frame(1'b1, 10'h35C, 1'b0);
        read_back(8'hC3);
        end_frame();
        send_frame(1'b1, 10'h2F1, 1'b0);
        no_capture();
        end_frame();

        // Sticky tx_valid: held through the frame and long after; only the first byte is sent.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        send_frame(1'b1, 10'h3E7, 1'b0);
        tx_data = sticky_b;
        tick();
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("sticky_bit%0d", i), 32'(MISO), 32'(sticky_b[i]));
            tx_data = 8'($urandom);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("sticky_idle", 32'(MISO), 32'(MI));
            tick();
        end
        tx_valid = 1'b0;
        end_frame();

        // Abort after 5 data bits, then a full frame must still decode.
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'($urandom);
            tick();
            check("abort_rxv", 32'(rx_valid), 32'(1'b0));
        end
        SS_n = 1'b1;
        tick();
        check("abort_rxv_ss", 32'(rx_valid), 32'(1'b0));
        check("abort_rx_hold", 32'(rx_data), 32'(last_rx));
        send_frame(1'b0, 10'h2C7, 1'b0);
        end_frame();

        // SS_n rising on the 10th-bit edge: frame still completes and sets rd_flag.
        send_frame(1'b1, 10'h155, 1'b1);
        end_frame();

        // Read data, then reset during the 4th MISO bit.
        send_frame(1'b1, 10'h3A0, 1'b0);
        tx_data  = rst_b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 7; i >= 5; i--) begin
            check($sformatf("pre_rst_bit%0d", i), 32'(MISO), 32'(rst_b[i]));
            tick();
        end
        check("pre_rst_bit4", 32'(MISO), 32'(rst_b[4]));
        rst_n = 1'b0;
        tick();
        check("midshift_rst_miso", 32'(MISO), 32'(MI));
        check("midshift_rst_rxv", 32'(rx_valid), 32'(1'b0));
        check("midshift_rst_rx_data", 32'(rx_data), 32'(10'h000));
        last_rx = 10'h000;
        rst_n = 1'b1;
        SS_n  = 1'b1;
        tick();
        send_frame(1'b1, 10'h2AA, 1'b0);
        no_capture();
        end_frame();

        // Reset while rd_flag is set: the next read frame is again a read address.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        last_rx = 10'h000;
        send_frame(1'b1, 10'h1CC, 1'b0);
        no_capture();
        end_frame();
        send_frame(1'b1, 10'h3C3, 1'b0);
        read_back(8'h3C);
        end_frame();

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
